pid_seq: RTL and testbench
==========================

Name: pid_seq

Overview:
- Sequences one PID update per accepted error sample.
- Flow per sample:
  - saturates the 16-bit signed error to 10 bits;
  - forms a 7-bit-saturated derivative difference against a history queue;
  - maintains a saturating 18-bit integrator;
  - time-shares one 10x6 signed multiplier between the P and D terms.
- Sits between the error-generation logic and the motor-drive stage.
- Produces one signed 16-bit command per sample, marked by a valid pulse.

Parameters:
- P_COEFF, 5'd12, proportional gain, unsigned 0..31.
- D_COEFF, 5'd7, derivative gain, unsigned 0..31.
- D_DEPTH, 2, history queue depth; the derivative uses the oldest entry. Legal range 1..8.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- err_vld  input  1  error sample strobe; accepted only in IDLE.
- err  input  16  signed error sample.
- int_clr  input  1  synchronous clear of integrator and history queue.
- pid_out  output  16  signed PID command, registered.
- out_vld  output  1  one-cycle pulse when pid_out updates.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Interface (already decided): one clock (clk); reset rst_n is asynchronous, active-low.
- Reset:
  - state=IDLE; pid_out=0, out_vld=0, busy=0.
  - integrator=0; all history entries=0; internal term registers=0.
  - Reset asserted mid-operation aborts the sample immediately. No out_vld is produced.
- FSM: IDLE -> SAT -> MUL_P -> MUL_D -> SUM -> IDLE, one cycle per state.
  - IDLE -> SAT only when err_vld=1; err is captured at that edge (E0).
  - err_vld outside IDLE is ignored and dropped. It is not queued.
- SAT (edge E1):
  - err_sat = err clamped to [-512, 511], 10-bit signed.
  - d_raw = err_sat - hist[D_DEPTH-1], 11-bit signed.
  - d_sat = d_raw clamped to [-64, 63], 7-bit signed.
- MUL_P (E2): p_term = err_sat * {1'b0,P_COEFF}, signed, sign-extended to 16 bits.
- MUL_D (E3):
  - d_term = sext10(d_sat) * {1'b0,D_COEFF}, 16-bit signed.
  - Same multiplier instance as MUL_P, operands selected by state.
- SUM (E4):
  - integ_nxt = integrator + sext18(err_sat), clamped to [-131072, 131071] (0x20000..0x1FFFF).
  - i_term = sext16(integ_nxt[17:6]), i.e. the updated value arithmetically shifted right by 6.
  - pid_out <= p_term + i_term + d_term. Worst case |sum| = 15872+2048+1984, so no overflow and no output clamp.
  - out_vld=1 for the cycle following E4.
  - integrator <= integ_nxt.
  - History shifts: hist[0] <= err_sat, hist[k] <= hist[k-1].
- Latency:
  - out_vld rises 4 edges after the accepting edge.
  - Next sample is accepted at E5 at the earliest, giving max throughput of 1 sample / 5 cycles.
- int_clr:
  - Takes effect at any edge where it is high: integrator=0 and history=0.
  - At the SUM edge, clear wins over the integrator/history update. pid_out still takes the computed sum and out_vld still pulses.
  - It does not alter FSM state.
- busy = (state != IDLE). It goes high in the cycle after E0 and low in the cycle after E4.

Decomposition:
- Package pid_pkg holds:
  - state enum;
  - width constants (ERR_W=16, SAT_W=10, DSAT_W=7, INTEG_W=18);
  - clamp limit constants;
  - a generic signed-clamp function used for the err, d and integrator clamps.
- One sub-module: pid_mul10x6, the shared registered signed multiplier with operand mux outside.

Test Plan:
- Reset, then err=16'h0010 with err_vld → at E4, pid_out=304 (P=192, I=0, D=112), out_vld one cycle, busy high for 4 cycles.
- From reset, err=16'h7FFF → err_sat=511, d_sat=63, pid_out=6132+7+441=6580.
- From reset, err=16'h8000 → err_sat=-512, d_sat=-64, pid_out=-6144-8-448=-6600.
- 260 back-to-back samples of 16'h7FFF → integrator clamps at 17'h1FFFF from sample 257 on. The steady state has hist all 511, so d_term=0 and pid_out=6132+2047=8179.
- err_vld held high continuously → samples accepted only at E0, E5, E10; exactly one out_vld per 5 cycles; intermediate values ignored.
- int_clr at the SUM edge of a sample → that sample's pid_out uses the computed sum, integrator and history read 0 afterwards. rst_n pulsed at MUL_P → no out_vld, all outputs 0.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared types, widths and clamp limits for the PID sequencer.
package pid_pkg;

    localparam int unsigned ERR_W   = 16;
    localparam int unsigned SAT_W   = 10;
    localparam int unsigned DSAT_W  = 7;
    localparam int unsigned INTEG_W = 18;
    localparam int unsigned COEF_W  = 6;
    localparam int unsigned TERM_W  = 16;

    localparam int ERR_MIN   = -512;
    localparam int ERR_MAX   = 511;
    localparam int D_MIN     = -64;
    localparam int D_MAX     = 63;
    localparam int INTEG_MIN = -131072;
    localparam int INTEG_MAX = 131071;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SAT   = 3'd1,
        ST_MUL_P = 3'd2,
        ST_MUL_D = 3'd3,
        ST_SUM   = 3'd4
    } state_e;

    // Clamp a sign-extended 32-bit value into [lo, hi]; callers truncate the result.
    function automatic logic signed [31:0] sclamp(input logic signed [31:0] v,
                                                  input int lo,
                                                  input int hi);
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/pid_mul10x6.sv
// Registered 10x6 signed multiplier shared between the P and D terms.
module pid_mul10x6
    import pid_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [SAT_W-1:0]  a,
    input  logic signed [COEF_W-1:0] b,
    output logic signed [TERM_W-1:0] p
);

    logic signed [TERM_W-1:0] a_x;
    logic signed [TERM_W-1:0] b_x;
    logic signed [TERM_W-1:0] p_d;
    logic signed [TERM_W-1:0] p_q;

    // Sign-extend both operands to the product width and form the next product.
    always_comb begin
        a_x = {{(TERM_W-SAT_W){a[SAT_W-1]}}, a};
        b_x = {{(TERM_W-COEF_W){b[COEF_W-1]}}, b};
        p_d = p_q;
        if (en) begin
            p_d = a_x * b_x;
        end
    end

    // Product register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/pid_seq.sv
// PID sequencer: one saturated P+I+D update per accepted error sample, five cycles each.
module pid_seq
    import pid_pkg::*;
#(
    parameter logic [4:0]  P_COEFF = 5'd12,
    parameter logic [4:0]  D_COEFF = 5'd7,
    parameter int unsigned D_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              err_vld,
    input  logic [ERR_W-1:0]  err,
    input  logic              int_clr,
    output logic [TERM_W-1:0] pid_out,
    output logic              out_vld,
    output logic              busy
);

    state_e state_q, state_d;

    logic signed [ERR_W-1:0]   err_q, err_d;
    logic signed [SAT_W-1:0]   err_sat_q, err_sat_d;
    logic signed [DSAT_W-1:0]  d_sat_q, d_sat_d;
    logic signed [TERM_W-1:0]  p_term_q, p_term_d;
    logic signed [INTEG_W-1:0] integ_q, integ_d;
    logic signed [SAT_W-1:0]   hist_q [D_DEPTH];
    logic signed [SAT_W-1:0]   hist_d [D_DEPTH];
    logic signed [TERM_W-1:0]  pid_out_q, pid_out_d;
    logic                      out_vld_q, out_vld_d;

    logic signed [SAT_W-1:0]   err_sat_c;
    logic signed [DSAT_W-1:0]  d_sat_c;
    logic signed [INTEG_W-1:0] integ_nxt;
    logic signed [TERM_W-1:0]  i_term;

    logic                      mul_en;
    logic signed [SAT_W-1:0]   mul_a;
    logic signed [COEF_W-1:0]  mul_b;
    logic signed [TERM_W-1:0]  mul_p;

    // Next-state logic for the fixed five-step sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (err_vld) state_d = ST_SAT;
            ST_SAT:   state_d = ST_MUL_P;
            ST_MUL_P: state_d = ST_MUL_D;
            ST_MUL_D: state_d = ST_SUM;
            ST_SUM:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Saturating arithmetic: error clamp, derivative clamp, integrator update.
    always_comb begin
        err_sat_c = SAT_W'(sclamp({{(32-ERR_W){err_q[ERR_W-1]}}, err_q}, ERR_MIN, ERR_MAX));
        d_sat_c   = DSAT_W'(sclamp({{(32-SAT_W){err_sat_c[SAT_W-1]}}, err_sat_c}
                                 - {{(32-SAT_W){hist_q[D_DEPTH-1][SAT_W-1]}}, hist_q[D_DEPTH-1]},
                                   D_MIN, D_MAX));
        integ_nxt = INTEG_W'(sclamp({{(32-INTEG_W){integ_q[INTEG_W-1]}}, integ_q}
                                   + {{(32-SAT_W){err_sat_q[SAT_W-1]}}, err_sat_q},
                                     INTEG_MIN, INTEG_MAX));
        i_term    = {{(TERM_W-(INTEG_W-6)){integ_nxt[INTEG_W-1]}}, integ_nxt[INTEG_W-1:6]};
    end

    // Multiplier operand select: P gain in MUL_P, D gain in MUL_D.
    always_comb begin
        mul_en = (state_q == ST_MUL_P) || (state_q == ST_MUL_D);
        if (state_q == ST_MUL_D) begin
            mul_a = {{(SAT_W-DSAT_W){d_sat_q[DSAT_W-1]}}, d_sat_q};
            mul_b = {1'b0, D_COEFF};
        end else begin
            mul_a = err_sat_q;
            mul_b = {1'b0, P_COEFF};
        end
    end

    pid_mul10x6 u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mul_en),
        .a     (mul_a),
        .b     (mul_b),
        .p     (mul_p)
    );

    // Datapath register updates per state; int_clr overrides integrator and history.
    // The P product is moved out of the multiplier register at the MUL_D edge,
    // leaving the D product in the multiplier register for the SUM edge.
    always_comb begin
        err_d     = err_q;
        err_sat_d = err_sat_q;
        d_sat_d   = d_sat_q;
        p_term_d  = p_term_q;
        integ_d   = integ_q;
        hist_d    = hist_q;
        pid_out_d = pid_out_q;
        out_vld_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (err_vld) err_d = signed'(err);
            end
            ST_SAT: begin
                err_sat_d = err_sat_c;
                d_sat_d   = d_sat_c;
            end
            ST_MUL_D: begin
                p_term_d = mul_p;
            end
            ST_SUM: begin
                integ_d   = integ_nxt;
                hist_d[0] = err_sat_q;
                for (int unsigned k = 1; k < D_DEPTH; k++) begin
                    hist_d[k] = hist_q[k-1];
                end
                pid_out_d = p_term_q + i_term + mul_p;
                out_vld_d = 1'b1;
            end
            default: ;
        endcase

        if (int_clr) begin
            integ_d = '0;
            for (int unsigned k = 0; k < D_DEPTH; k++) begin
                hist_d[k] = '0;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            err_q     <= '0;
            err_sat_q <= '0;
            d_sat_q   <= '0;
            p_term_q  <= '0;
            integ_q   <= '0;
            pid_out_q <= '0;
            out_vld_q <= 1'b0;
            for (int unsigned k = 0; k < D_DEPTH; k++) begin
                hist_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            err_sat_q <= err_sat_d;
            d_sat_q   <= d_sat_d;
            p_term_q  <= p_term_d;
            integ_q   <= integ_d;
            pid_out_q <= pid_out_d;
            out_vld_q <= out_vld_d;
            for (int unsigned k = 0; k < D_DEPTH; k++) begin
                hist_q[k] <= hist_d[k];
            end
        end
    end

    assign pid_out = pid_out_q;
    assign out_vld = out_vld_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pid_seq.sv
// Directed bench for pid_seq with hand-computed PID results.
module tb_pid_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        err_vld;
    logic [15:0] err;
    logic        int_clr;
    logic [15:0] pid_out;
    logic        out_vld;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pid_seq #(
        .P_COEFF (5'd12),
        .D_COEFF (5'd7),
        .D_DEPTH (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .err_vld (err_vld),
        .err     (err),
        .int_clr (int_clr),
        .pid_out (pid_out),
        .out_vld (out_vld),
        .busy    (busy)
    );

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        err_vld = 1'b0;
        int_clr = 1'b0;
        err     = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_pid", sx(pid_out), 0);
        chk("rst_vld", {31'd0, out_vld}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
    endtask

    // Issue one sample and check the fixed 4-edge latency, busy window and result.
    task automatic send(input logic [15:0] v, input int exp, input bit clr, input string tag);
        @(negedge clk);
        err     = v;
        err_vld = 1'b1;
        @(negedge clk);
        err_vld = 1'b0;
        err     = 16'h5A5A;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk);
            chk({tag, "_busy"}, {31'd0, busy}, 1);
            chk({tag, "_early_vld"}, {31'd0, out_vld}, 0);
            if (k == 4 && clr) int_clr = 1'b1;
        end
        @(negedge clk);
        int_clr = 1'b0;
        chk({tag, "_vld"}, {31'd0, out_vld}, 1);
        chk({tag, "_idle"}, {31'd0, busy}, 0);
        chk({tag, "_pid"}, sx(pid_out), exp);
    endtask

    initial begin : wdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int exp_cont [3];
        int got;
        int integ;
        int expv;

        // Basic sample and saturation corners, each from reset.
        do_reset();
        send(16'h0010, 304, 1'b0, "small_pos");
        do_reset();
        send(16'hFFF0, -305, 1'b0, "small_neg");
        do_reset();
        send(16'h7FFF, 6580, 1'b0, "max_pos");
        do_reset();
        send(16'h8000, -6600, 1'b0, "max_neg");
        do_reset();
        send(16'h0200, 6580, 1'b0, "just_over");
        do_reset();
        send(16'hFDFF, -6600, 1'b0, "just_under");

        // Long run of full-scale samples drives the integrator into its clamp.
        do_reset();
        for (int i = 1; i <= 260; i++) begin
            integ = 511 * i;
            if (integ > 131071) integ = 131071;
            expv = 6132 + (integ >>> 6) + ((i <= 2) ? 441 : 0);
            send(16'h7FFF, expv, 1'b0, $sformatf("run%0d", i));
        end

        // err_vld held high: only every fifth edge accepts a sample.
        do_reset();
        exp_cont[0] = 304;
        exp_cont[1] = 608;
        exp_cont[2] = -112;
        got = 0;
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            chk($sformatf("cont_vld%0d", c), {31'd0, out_vld}, (c == 5 || c == 10 || c == 15) ? 1 : 0);
            chk($sformatf("cont_busy%0d", c), {31'd0, busy}, (c % 5 == 0) ? 0 : 1);
            if (out_vld === 1'b1) begin
                if (got < 3) chk($sformatf("cont_pid%0d", got), sx(pid_out), exp_cont[got]);
                got++;
            end
            err_vld = 1'b1;
            err = (c == 0) ? 16'h0010 : (c == 5) ? 16'h0020 : (c == 10) ? 16'h0000 : 16'h7FFF;
        end
        err_vld = 1'b0;
        chk("cont_count", got, 3);

        // int_clr on the SUM edge keeps that result but clears integrator and history.
        do_reset();
        send(16'h7FFF, 6580, 1'b0, "clr_a");
        send(16'h7FFF, 6588, 1'b1, "clr_b");
        send(16'h0010, 304, 1'b0, "clr_after");

        // Reset asserted during MUL_P aborts the sample.
        do_reset();
        send(16'h0010, 304, 1'b0, "abort_pre");
        @(negedge clk);
        err     = 16'h7FFF;
        err_vld = 1'b1;
        @(negedge clk);
        err_vld = 1'b0;
        @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_pid", sx(pid_out), 0);
        chk("abort_busy", {31'd0, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_vld !== 1'b0) got++;
            if (c == 7) begin
                chk("abort_no_vld", got, 0);
                chk("abort_pid_hold", sx(pid_out), 0);
                chk("abort_idle", {31'd0, busy}, 0);
            end
        end
        send(16'h0010, 304, 1'b0, "abort_post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
